dense_layer_seq: RTL and testbench

Time-multiplexed, handshaked successor to the combinational dense layer. It computes dout[j] = act(sat((biases[j] + sum_i din[i]*weights[i][j]) >>> SHIFT)) for every output j. P parallel MAC lanes are reused over D2/P output groups, with signed arithmetic, a wide accumulator, saturation and runtime-selectable ReLU. It sits between MLP stages; each stage's valid/ready output feeds the next stage's input.

---
 rtl/dense_layer_seq.sv | 199 +++++++++++++++++++
 tb/tb_dense_layer_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed dense layer with valid/ready handshakes.
//   dout[j] = act(sat((biases[j] + sum_i din[i]*weights[i][j]) >>> SHIFT))
// P MAC lanes are reused over G = D2/P output groups. Each group takes D1 edges.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; din and relu_en are captured on accept
//   din       [D1*IN_W]   signed input vector, element i at bits [i*IN_W +: IN_W]
//   relu_en               per-vector ReLU enable
//   weights   [D1*D2*W_W] signed weights, weights[i][j] at [(i*D2+j)*W_W +: W_W]
//   biases    [D2*ACC_W]  signed biases at accumulator scale, element j at [j*ACC_W +: ACC_W]
//   out_valid / out_ready output handshake
//   dout      [D2*OUT_W]  signed result vector, element j at [j*OUT_W +: OUT_W]
//   sat_flag              at least one element of the current result was clamped
//   busy                  high in MAC or DONE
//
// state | meaning
// IDLE  | ready for a new vector
// MAC   | accumulating group g, input index i
// DONE  | result presented, waiting for out_ready
module dense_layer_seq #(
    parameter int D1    = 16,
    parameter int D2    = 8,
    parameter int P     = 2,
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 24,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [D1*IN_W-1:0]     din,
    input  logic                   relu_en,
    input  logic [D1*D2*W_W-1:0]   weights,
    input  logic [D2*ACC_W-1:0]    biases,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [D2*OUT_W-1:0]    dout,
    output logic                   sat_flag,
    output logic                   busy
);

    localparam int G  = D2 / P;
    localparam int IW = (D1 > 1) ? $clog2(D1) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(D1 - 1);
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);
    localparam int OMAX_I = (1 << (OUT_W - 1)) - 1;
    localparam int OMIN_I = -(1 << (OUT_W - 1));
    localparam logic signed [ACC_W-1:0] OMAX = ACC_W'(OMAX_I);
    localparam logic signed [ACC_W-1:0] OMIN = ACC_W'(OMIN_I);

    if (D2 % P != 0) begin : g_chk_lanes
        $error("dense_layer_seq: D2 must be a multiple of P");
    end
    if (ACC_W < IN_W + W_W + $clog2(D1) + 1) begin : g_chk_acc
        $error("dense_layer_seq: ACC_W too narrow for worst-case sum");
    end

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state_q, state_d;
    logic [D1*IN_W-1:0]       din_q, din_d;
    logic                     relu_q, relu_d;
    logic signed [ACC_W-1:0]  acc_q [P];
    logic signed [ACC_W-1:0]  acc_d [P];
    logic [IW-1:0]            i_q, i_d;
    logic [GW-1:0]            g_q, g_d;
    logic [D2*OUT_W-1:0]      dout_q, dout_d;
    logic                     sat_q, sat_d;

    logic signed [IN_W+W_W-1:0] prod_w [P];
    logic signed [ACC_W-1:0]    sum_w  [P];
    logic signed [ACC_W-1:0]    shr_w  [P];
    logic [OUT_W-1:0]           res_w  [P];
    logic                       sat_w  [P];
    logic                       any_sat_w;

    // Per-lane datapath: full-precision product, wrapping accumulate, then
    // shift -> ReLU -> clamp on the running sum (only used on the last i).
    always_comb begin
        any_sat_w = 1'b0;
        for (int l = 0; l < P; l++) begin
            prod_w[l] = $signed(din_q[int'(i_q)*IN_W +: IN_W])
                      * $signed(weights[(int'(i_q)*D2 + int'(g_q)*P + l)*W_W +: W_W]);
            sum_w[l]  = acc_q[l] + ACC_W'(prod_w[l]);
            shr_w[l]  = sum_w[l] >>> SHIFT;
            if (relu_q && (shr_w[l] < 0)) begin
                shr_w[l] = '0;
            end
            sat_w[l] = 1'b0;
            res_w[l] = shr_w[l][OUT_W-1:0];
            if (shr_w[l] > OMAX) begin
                res_w[l] = OMAX[OUT_W-1:0];
                sat_w[l] = 1'b1;
            end else if (shr_w[l] < OMIN) begin
                res_w[l] = OMIN[OUT_W-1:0];
                sat_w[l] = 1'b1;
            end
            any_sat_w = any_sat_w | sat_w[l];
        end
    end

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        relu_d    = relu_q;
        acc_d     = acc_q;
        i_d       = i_q;
        g_d       = g_q;
        dout_d    = dout_q;
        sat_d     = sat_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    din_d  = din;
                    relu_d = relu_en;
                    for (int l = 0; l < P; l++) begin
                        acc_d[l] = biases[l*ACC_W +: ACC_W];
                    end
                    i_d     = '0;
                    g_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                for (int l = 0; l < P; l++) begin
                    acc_d[l] = sum_w[l];
                end
                i_d = i_q + 1'b1;
                if (i_q == I_LAST) begin
                    for (int l = 0; l < P; l++) begin
                        dout_d[(int'(g_q)*P + l)*OUT_W +: OUT_W] = res_w[l];
                    end
                    sat_d = sat_q | any_sat_w;
                    i_d   = '0;
                    if (g_q == G_LAST) begin
                        state_d = DONE;
                    end else begin
                        g_d = g_q + 1'b1;
                        // Preload the next group's biases so its first MAC edge adds onto them.
                        for (int l = 0; l < P; l++) begin
                            acc_d[l] = biases[((int'(g_q) + 1)*P + l)*ACC_W +: ACC_W];
                        end
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    sat_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            din_q   <= '0;
            relu_q  <= 1'b0;
            i_q     <= '0;
            g_q     <= '0;
            dout_q  <= '0;
            sat_q   <= 1'b0;
            for (int l = 0; l < P; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            relu_q  <= relu_d;
            i_q     <= i_d;
            g_q     <= g_d;
            dout_q  <= dout_d;
            sat_q   <= sat_d;
            for (int l = 0; l < P; l++) begin
                acc_q[l] <= acc_d[l];
            end
        end
    end

    assign dout     = dout_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
module tb_dense_layer_seq;
    localparam int D1 = 4, D2 = 4, P = 2, IN_W = 8, W_W = 8, ACC_W = 24, OUT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  in_valid, relu_en, out_ready;
    logic [D1*IN_W-1:0]    din;
    logic [D1*D2*W_W-1:0]  weights;
    logic [D2*ACC_W-1:0]   biases;
    logic                  in_ready0, out_valid0, sat0, busy0;
    logic                  in_ready1, out_valid1, sat1, busy1;
    logic [D2*OUT_W-1:0]   dout0, dout1;

    dense_layer_seq #(.D1(D1), .D2(D2), .P(P), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W),
                      .OUT_W(OUT_W), .SHIFT(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .din(din),
        .relu_en(relu_en), .weights(weights), .biases(biases), .out_valid(out_valid0),
        .out_ready(out_ready), .dout(dout0), .sat_flag(sat0), .busy(busy0));

    dense_layer_seq #(.D1(D1), .D2(D2), .P(P), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W),
                      .OUT_W(OUT_W), .SHIFT(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .din(din),
        .relu_en(relu_en), .weights(weights), .biases(biases), .out_valid(out_valid1),
        .out_ready(out_ready), .dout(dout1), .sat_flag(sat1), .busy(busy1));

    int din_a [D1];
    int w_a   [D1][D2];
    int b_a   [D2];
    bit relu_a;
    int n_chk = 0;
    int n_pass = 0;

    // Reference: plain integer arithmetic on the stored vector.
    function automatic void model(input int sh, output logic [D2*OUT_W-1:0] dexp, output logic sexp);
        int sum, r;
        sexp = 1'b0;
        dexp = '0;
        for (int j = 0; j < D2; j++) begin
            sum = b_a[j];
            for (int i = 0; i < D1; i++) sum += din_a[i] * w_a[i][j];
            r = sum >>> sh;
            if (relu_a && r < 0) r = 0;
            if (r > 127) begin r = 127; sexp = 1'b1; end
            else if (r < -128) begin r = -128; sexp = 1'b1; end
            dexp[j*OUT_W +: OUT_W] = r[7:0];
        end
    endfunction

    task automatic set_all(input int dv, input int wv, input int bv, input bit rl);
        for (int i = 0; i < D1; i++) din_a[i] = dv;
        for (int i = 0; i < D1; i++) for (int j = 0; j < D2; j++) w_a[i][j] = wv;
        for (int j = 0; j < D2; j++) b_a[j] = bv;
        relu_a = rl;
    endtask

    task automatic set_random();
        for (int i = 0; i < D1; i++) din_a[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < D1; i++) for (int j = 0; j < D2; j++) w_a[i][j] = int'($urandom_range(0, 255)) - 128;
        for (int j = 0; j < D2; j++) b_a[j] = int'($urandom_range(0, 4000)) - 2000;
        relu_a = bit'($urandom_range(0, 1));
    endtask

    task automatic drive_bus();
        int v;
        for (int i = 0; i < D1; i++) begin v = din_a[i]; din[i*IN_W +: IN_W] = v[7:0]; end
        for (int i = 0; i < D1; i++) for (int j = 0; j < D2; j++) begin
            v = w_a[i][j]; weights[(i*D2+j)*W_W +: W_W] = v[7:0];
        end
        for (int j = 0; j < D2; j++) begin v = b_a[j]; biases[j*ACC_W +: ACC_W] = v[23:0]; end
        relu_en = relu_a;
    endtask

    // Offers the stored vector, scrambles din/relu_en after accept, returns edges to out_valid (-1 on timeout).
    task automatic run_vector(output int lat);
        int k;
        drive_bus();
        @(negedge clk);
        in_valid = 1'b1;
        k = 0;
        while (!in_ready0 && k < 50) begin @(negedge clk); k++; end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din = $urandom();
        relu_en = ~relu_a;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (out_valid0) begin lat = c; break; end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0 || sat0 !== 1'b0 || dout0 !== '0 ||
            in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || dout1 !== '0)
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b sat=%b dout=%h dout_s2=%h, want 1 0 0 0 0 0",
                     in_ready0, out_valid0, busy0, sat0, dout0, dout1);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        logic [D2*OUT_W-1:0] e0, e2;
        logic s0, s2;
        set_all(1, 2, 0, 1'b0);
        run_vector(lat);
        model(0, e0, s0);
        model(2, e2, s2);
        n_chk++;
        if (lat !== 8) $display("FAIL basic_latency: got %0d want 8", lat); else n_pass++;
        n_chk++;
        if (dout0 !== 32'h08080808 || sat0 !== 1'b0)
            $display("FAIL basic_const: got %h sat %b want 08080808 sat 0", dout0, sat0);
        else n_pass++;
        n_chk++;
        if (dout0 !== e0 || sat0 !== s0 || dout1 !== e2 || sat1 !== s2 || out_valid1 !== 1'b1)
            $display("FAIL basic_model: got %h/%b %h/%b want %h/%b %h/%b", dout0, sat0, dout1, sat1, e0, s0, e2, s2);
        else n_pass++;
        handshake();
        n_chk++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1)
            $display("FAIL basic_handshake: vld=%b rdy=%b want 0 1", out_valid0, in_ready0);
        else n_pass++;
    endtask

    task automatic test_relu();
        int lat;
        logic [D2*OUT_W-1:0] e0, e2;
        logic s0, s2;
        for (int k = 0; k < 3; k++) begin
            set_all(2, -3, 5, (k == 0));
            if (k == 2) begin b_a[0] = 0; b_a[1] = 10; b_a[2] = 30; b_a[3] = 40; end
            run_vector(lat);
            model(0, e0, s0);
            model(2, e2, s2);
            n_chk++;
            if (lat !== 8 || dout0 !== e0 || sat0 !== s0 || dout1 !== e2 || sat1 !== s2)
                $display("FAIL relu_%0d: lat %0d got %h/%b %h/%b want %h/%b %h/%b",
                         k, lat, dout0, sat0, dout1, sat1, e0, s0, e2, s2);
            else n_pass++;
            handshake();
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [D2*OUT_W-1:0] e0, e2;
        logic s0, s2;
        for (int k = 0; k < 2; k++) begin
            set_all(127, (k == 0) ? 127 : -128, 0, 1'b0);
            run_vector(lat);
            model(0, e0, s0);
            model(2, e2, s2);
            n_chk++;
            if (lat !== 8 || dout0 !== e0 || sat0 !== s0 || s0 !== 1'b1 || dout1 !== e2 || sat1 !== s2)
                $display("FAIL sat_%0d: lat %0d got %h/%b %h/%b want %h/%b %h/%b",
                         k, lat, dout0, sat0, dout1, sat1, e0, s0, e2, s2);
            else n_pass++;
            handshake();
            n_chk++;
            if (sat0 !== 1'b0 || sat1 !== 1'b0)
                $display("FAIL sat_clear_%0d: got %b %b want 0 0", k, sat0, sat1);
            else n_pass++;
        end
    endtask

    task automatic test_shift();
        int lat;
        logic [D2*OUT_W-1:0] e0, e2;
        logic s0, s2;
        set_all(0, 5, 0, 1'b0);
        b_a[0] = -7; b_a[1] = 7; b_a[2] = 1023; b_a[3] = 0;
        run_vector(lat);
        model(0, e0, s0);
        model(2, e2, s2);
        n_chk++;
        if (dout1 !== 32'h007F01FE || sat1 !== 1'b1)
            $display("FAIL shift_const: got %h sat %b want 007f01fe sat 1", dout1, sat1);
        else n_pass++;
        n_chk++;
        if (dout0 !== e0 || sat0 !== s0 || dout1 !== e2 || sat1 !== s2)
            $display("FAIL shift_model: got %h/%b %h/%b want %h/%b %h/%b", dout0, sat0, dout1, sat1, e0, s0, e2, s2);
        else n_pass++;
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [D2*OUT_W-1:0] e0, e2;
        logic s0, s2;
        set_random();
        run_vector(lat);
        model(0, e0, s0);
        model(2, e2, s2);
        n_chk++;
        if (lat !== 8 || dout0 !== e0 || sat0 !== s0 || dout1 !== e2 || sat1 !== s2)
            $display("FAIL bp_result: lat %0d got %h/%b %h/%b want %h/%b %h/%b",
                     lat, dout0, sat0, dout1, sat1, e0, s0, e2, s2);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1 ^ c[0];
            din = $urandom();
            @(posedge clk);
            #1;
            n_chk++;
            if (dout0 !== e0 || sat0 !== s0 || dout1 !== e2 || sat1 !== s2 ||
                in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || busy0 !== 1'b1)
                $display("FAIL bp_hold_%0d: got %h/%b rdy %b vld %b want %h/%b rdy 0 vld 1",
                         c, dout0, sat0, in_ready0, out_valid0, e0, s0);
            else n_pass++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake();
        n_chk++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0)
            $display("FAIL bp_release: vld=%b rdy=%b busy=%b want 0 1 0", out_valid0, in_ready0, busy0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [D2*OUT_W-1:0] e0, e2;
        logic s0, s2;
        for (int n = 0; n < 12; n++) begin
            set_random();
            if (n % 3 == 0) for (int j = 0; j < D2; j++) b_a[j] = b_a[j] * 30;
            run_vector(lat);
            model(0, e0, s0);
            model(2, e2, s2);
            n_chk++;
            if (lat !== 8 || dout0 !== e0 || sat0 !== s0 || dout1 !== e2 || sat1 !== s2)
                $display("FAIL b2b_%0d: lat %0d got %h/%b %h/%b want %h/%b %h/%b",
                         n, lat, dout0, sat0, dout1, sat1, e0, s0, e2, s2);
            else n_pass++;
            handshake();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [D2*OUT_W-1:0] e0, e2;
        logic s0, s2;
        set_random();
        drive_bus();
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || dout0 !== '0 || busy0 !== 1'b0 ||
            out_valid1 !== 1'b0 || dout1 !== '0)
            $display("FAIL reset_mid: vld=%b rdy=%b busy=%b dout=%h dout_s2=%h want 0 1 0 0 0",
                     out_valid0, in_ready0, busy0, dout0, dout1);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        set_random();
        run_vector(lat);
        model(0, e0, s0);
        model(2, e2, s2);
        n_chk++;
        if (lat !== 8 || dout0 !== e0 || sat0 !== s0 || dout1 !== e2 || sat1 !== s2)
            $display("FAIL reset_recover: lat %0d got %h/%b %h/%b want %h/%b %h/%b",
                     lat, dout0, sat0, dout1, sat1, e0, s0, e2, s2);
        else n_pass++;
        handshake();
    endtask

    initial begin
        in_valid = 1'b0;
        relu_en = 1'b0;
        out_ready = 1'b0;
        din = '0;
        weights = '0;
        biases = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_relu();
        test_saturation();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
